// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if -- consumer-side bus of the PS/2 receiver FIFO.
//
// Groups the byte-pull handshake and the error reporting signals.
//   slave  modport : used by ps2_rx_fifo (drives data/status, reads rdreq/clr_err)
//   master modport : used by the consumer logic
// Signals:
//   rdreq      consumer -> rx  pop FIFO head this cycle
//   clr_err    consumer -> rx  clear sticky error flags
//   char       rx -> consumer  FIFO head byte, valid when empty=0
//   empty      rx -> consumer  FIFO empty
//   full       rx -> consumer  FIFO full
//   count      rx -> consumer  FIFO occupancy
//   err_pulse  rx -> consumer  one-cycle {overflow, frame_err, parity_err}
//   err_sticky rx -> consumer  sticky copy of err_pulse
//   ext_tag    rx -> consumer  head byte was preceded by 0xE0 (PS2_SCANCODE_TAG_EN only)
//   brk_tag    rx -> consumer  head byte was preceded by 0xF0 (PS2_SCANCODE_TAG_EN only)
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          rdreq;
  logic                          clr_err;
  logic [7:0]                    char;
  logic                          empty;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic [2:0]                    err_pulse;
  logic [2:0]                    err_sticky;
`ifdef PS2_SCANCODE_TAG_EN
  logic                          ext_tag;
  logic                          brk_tag;
`endif

`ifdef PS2_SCANCODE_TAG_EN
  modport slave (
    input  rdreq, clr_err,
    output char, empty, full, count, err_pulse, err_sticky, ext_tag, brk_tag
  );
  modport master (
    output rdreq, clr_err,
    input  char, empty, full, count, err_pulse, err_sticky, ext_tag, brk_tag
  );
`else
  modport slave (
    input  rdreq, clr_err,
    output char, empty, full, count, err_pulse, err_sticky
  );
  modport master (
    output rdreq, clr_err,
    input  char, empty, full, count, err_pulse, err_sticky
  );
`endif
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 device-to-host receiver with a show-ahead byte FIFO.
//
// Synchronises and deglitches the raw PS/2 pins, decodes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), checks parity/framing, aborts
// stalled frames after TIMEOUT_CYC cycles and queues good bytes.
//
// Optional feature macro: PS2_SCANCODE_TAG_EN
//   When defined, 0xE0/0xF0 prefix bytes are absorbed and attached as
//   ext_tag/brk_tag to the next byte; the FIFO is 10 bits wide.
//
// Ports:
//   fpga_clk  system clock, rising edge
//   rst_n     synchronous active-low reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   bus       ps2_rx_fifo_if.slave: rdreq, clr_err, char, empty, full,
//             count, err_pulse, err_sticky (+ ext_tag, brk_tag)
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic         fpga_clk,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_rx_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
`ifdef PS2_SCANCODE_TAG_EN
  localparam int WORD_W = 10;
`else
  localparam int WORD_W = 8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic              clk_s1, clk_s2, data_s1, data_s2;
  logic              filt_clk, filt_clk_d;
  logic [7:0]        filt_cnt;
  logic              strobe;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_ok;
  logic [TMO_W-1:0]  tmo_cnt;
`ifdef PS2_SCANCODE_TAG_EN
  logic              pend_ext, pend_brk;
  logic              is_prefix;
`endif

  logic              stop_hit, byte_ok, timeout_hit;
  logic              push_req, pop, wr_en, overflow;
  logic              frame_err_set, parity_err_set;
  logic [2:0]        err_set;
  logic [WORD_W-1:0] push_word;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_full, fifo_empty;
  logic [2:0]        err_pulse_q, err_sticky_q;

  // Two-flop synchronisers; idle-high reset value matches an idle PS/2 line.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered clock follows only after FILTER_LEN consecutive differing
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= 8'd0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == 8'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= 8'd0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= 8'd0;
      end
    end
  end

  assign strobe = filt_clk_d & ~filt_clk;

  // Frame completion decisions are combinational so the FIFO write lands at
  // the end of the stop-bit strobe cycle.
  assign stop_hit       = strobe && (state == ST_STOP);
  assign byte_ok        = stop_hit && data_s2 && par_ok;
  assign timeout_hit    = (state != ST_IDLE) && !strobe &&
                          (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign frame_err_set  = (stop_hit && !data_s2) || timeout_hit;
  assign parity_err_set = stop_hit && data_s2 && !par_ok;

`ifdef PS2_SCANCODE_TAG_EN
  assign is_prefix = (shift == 8'hE0) || (shift == 8'hF0);
  assign push_req  = byte_ok && !is_prefix;
  assign push_word = {pend_brk, pend_ext, shift};
`else
  assign push_req  = byte_ok;
  assign push_word = shift;
`endif

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop        = bus.rdreq && !fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
  assign wr_en      = push_req && (!fifo_full || pop);
  assign overflow   = push_req && fifo_full && !pop;
  assign err_set    = {overflow, frame_err_set, parity_err_set};

  // Frame decoder. The timeout counter runs only inside a frame and is
  // restarted by each falling edge.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      par_ok  <= 1'b0;
      tmo_cnt <= '0;
`ifdef PS2_SCANCODE_TAG_EN
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
`endif
    end else if (timeout_hit) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
`ifdef PS2_SCANCODE_TAG_EN
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
`endif
    end else begin
      if (state == ST_IDLE || strobe) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok <= (data_s2 == ~^shift);
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
`ifdef PS2_SCANCODE_TAG_EN
            if (!data_s2) begin
              pend_ext <= 1'b0;
              pend_brk <= 1'b0;
            end else if (par_ok) begin
              if (shift == 8'hE0) begin
                pend_ext <= 1'b1;
              end else if (shift == 8'hF0) begin
                pend_brk <= 1'b1;
              end else begin
                pend_ext <= 1'b0;
                pend_brk <= 1'b0;
              end
            end
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is left unreset so it can map onto RAM; empty gates the output.
  always_ff @(posedge fpga_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // A new error wins over a clear requested in the same cycle.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      err_pulse_q  <= 3'b000;
      err_sticky_q <= 3'b000;
    end else begin
      err_pulse_q  <= err_set;
      err_sticky_q <= (bus.clr_err ? 3'b000 : err_sticky_q) | err_set;
    end
  end

  assign bus.char       = fifo_empty ? 8'h00 : mem[rd_ptr][7:0];
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.count      = cnt_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
`ifdef PS2_SCANCODE_TAG_EN
  assign bus.ext_tag    = fifo_empty ? 1'b0 : mem[rd_ptr][8];
  assign bus.brk_tag    = fifo_empty ? 1'b0 : mem[rd_ptr][9];
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo -- directed self-checking bench for ps2_rx_fifo.
// fpga_clk period 750 ns so an 80-cycle PS/2 bit is a 60 us bit period;
// TIMEOUT_CYC is shortened to 200 cycles to keep runs short.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 200;
  localparam int FIFO_DEPTH  = 16;

  logic fpga_clk = 1'b0;
  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  int vec_count  = 0;
  int miss_count = 0;
  int par_total  = 0;
  int frm_total  = 0;
  int ovf_total  = 0;
  int par_snap, frm_snap, ovf_snap;

  ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  ps2_rx_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .fpga_clk(fpga_clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  always #375 fpga_clk = ~fpga_clk;

  // Count the cycles each error strobe is high, sampled mid-cycle.
  always @(negedge fpga_clk) begin
    if (bus.err_pulse[0]) par_total++;
    if (bus.err_pulse[1]) frm_total++;
    if (bus.err_pulse[2]) ovf_total++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Send the first nbits of a frame. Odd parity is computed here and
  // optionally inverted; glitch adds a 2-cycle low blip in each high phase;
  // pop_at_stop raises rdreq in the exact cycle the stop bit is pushed.
  task automatic applyStimulus(input logic [7:0] data, input bit bad_par,
                               input logic stop_bit, input int nbits,
                               input bit glitch, input bit pop_at_stop);
    logic [10:0] word;
    word = {stop_bit, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge fpga_clk);
      ps2_data = word[i];
      repeat (20) @(negedge fpga_clk);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_stop) begin
        repeat (10) @(negedge fpga_clk);
        bus.rdreq = 1'b1;
        @(negedge fpga_clk);
        bus.rdreq = 1'b0;
        repeat (29) @(negedge fpga_clk);
      end else begin
        repeat (40) @(negedge fpga_clk);
      end
      ps2_clk = 1'b1;
      if (glitch) begin
        repeat (12) @(negedge fpga_clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge fpga_clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge fpga_clk);
      end else begin
        repeat (20) @(negedge fpga_clk);
      end
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge fpga_clk);
  endtask

  task automatic popOne();
    @(negedge fpga_clk);
    bus.rdreq = 1'b1;
    @(negedge fpga_clk);
    bus.rdreq = 1'b0;
  endtask

  task automatic clearErr();
    @(negedge fpga_clk);
    bus.clr_err = 1'b1;
    @(negedge fpga_clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic snapErr();
    par_snap = par_total;
    frm_snap = frm_total;
    ovf_snap = ovf_total;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_char"},   bus.char, 0);
    checkOutput({tag, "_empty"},  bus.empty, 1);
    checkOutput({tag, "_full"},   bus.full, 0);
    checkOutput({tag, "_count"},  bus.count, 0);
    checkOutput({tag, "_pulse"},  bus.err_pulse, 0);
    checkOutput({tag, "_sticky"}, bus.err_sticky, 0);
  endtask

  initial begin
    bus.rdreq   = 1'b0;
    bus.clr_err = 1'b0;

    repeat (4) @(negedge fpga_clk);
    checkReset("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge fpga_clk);

    // Clean frame 0x1C then a single pop
    snapErr();
    applyStimulus(8'h1C, 0, 1'b1, 11, 0, 0);
    checkOutput("good_empty", bus.empty, 0);
    checkOutput("good_char",  bus.char, 8'h1C);
    checkOutput("good_count", bus.count, 1);
    checkOutput("good_noerr", par_total + frm_total + ovf_total
                              - par_snap - frm_snap - ovf_snap, 0);
    popOne();
    checkOutput("pop_empty", bus.empty, 1);
    checkOutput("pop_count", bus.count, 0);

    // Parity error
    snapErr();
    applyStimulus(8'h1C, 1, 1'b1, 11, 0, 0);
    checkOutput("par_pulse_cycles", par_total - par_snap, 1);
    checkOutput("par_frm_none",     frm_total - frm_snap, 0);
    checkOutput("par_sticky",       bus.err_sticky, 3'b001);
    checkOutput("par_empty",        bus.empty, 1);
    clearErr();
    checkOutput("par_clr_sticky",   bus.err_sticky, 0);

    // Stop bit 0 (bad parity too: must report framing only)
    snapErr();
    applyStimulus(8'h3C, 1, 1'b0, 11, 0, 0);
    checkOutput("stop_frm_cycles", frm_total - frm_snap, 1);
    checkOutput("stop_par_none",   par_total - par_snap, 0);
    checkOutput("stop_sticky",     bus.err_sticky, 3'b010);
    checkOutput("stop_empty",      bus.empty, 1);
    clearErr();

    // Timeout after start + 4 data bits, then a clean 0x5A
    snapErr();
    applyStimulus(8'h33, 0, 1'b1, 5, 0, 0);
    checkOutput("tmo_not_early", frm_total - frm_snap, 0);
    repeat (TIMEOUT_CYC + 50) @(negedge fpga_clk);
    checkOutput("tmo_frm_cycles", frm_total - frm_snap, 1);
    checkOutput("tmo_empty",      bus.empty, 1);
    applyStimulus(8'h5A, 0, 1'b1, 11, 0, 0);
    checkOutput("after_tmo_char",  bus.char, 8'h5A);
    checkOutput("after_tmo_count", bus.count, 1);
    checkOutput("after_tmo_frm",   frm_total - frm_snap, 1);
    popOne();
    clearErr();

    // Fill to full and overflow on the 17th byte
    snapErr();
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      applyStimulus(8'(i), 0, 1'b1, 11, 0, 0);
      if (i == FIFO_DEPTH - 1) begin
        checkOutput("fill_no_ovf", ovf_total - ovf_snap, 0);
      end
    end
    checkOutput("ovf_cycles",  ovf_total - ovf_snap, 1);
    checkOutput("ovf_full",    bus.full, 1);
    checkOutput("ovf_count",   bus.count, FIFO_DEPTH);
    checkOutput("ovf_head",    bus.char, 8'h00);
    checkOutput("ovf_sticky",  bus.err_sticky, 3'b100);
    clearErr();

    // Push and pop in the same cycle while full
    snapErr();
    applyStimulus(8'h20, 0, 1'b1, 11, 0, 1);
    checkOutput("pp_no_ovf", ovf_total - ovf_snap, 0);
    checkOutput("pp_count",  bus.count, FIFO_DEPTH);
    checkOutput("pp_full",   bus.full, 1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      checkOutput($sformatf("drain_%0d", i), bus.char,
                  (i < FIFO_DEPTH - 1) ? 32'(i + 1) : 32'h20);
      popOne();
    end
    checkOutput("drain_empty", bus.empty, 1);
    popOne();
    checkOutput("pop_on_empty_count", bus.count, 0);
    checkOutput("pop_on_empty_err",   ovf_total - ovf_snap, 0);

    // Glitched frame 0x29 must decode cleanly
    snapErr();
    applyStimulus(8'h29, 0, 1'b1, 11, 1, 0);
    checkOutput("glitch_char",  bus.char, 8'h29);
    checkOutput("glitch_count", bus.count, 1);
    checkOutput("glitch_noerr", par_total + frm_total - par_snap - frm_snap, 0);

    // Leave a sticky error and a queued byte, then reset mid-frame
    applyStimulus(8'h11, 1, 1'b1, 11, 0, 0);
    checkOutput("pre_rst_sticky", bus.err_sticky, 3'b001);
    applyStimulus(8'h77, 0, 1'b1, 5, 0, 0);
    @(negedge fpga_clk);
    rst_n = 1'b0;
    repeat (3) @(negedge fpga_clk);
    checkReset("midrst");
    rst_n = 1'b1;
    repeat (10) @(negedge fpga_clk);
    snapErr();
    applyStimulus(8'h29, 0, 1'b1, 11, 0, 0);
    checkOutput("post_rst_char",  bus.char, 8'h29);
    checkOutput("post_rst_count", bus.count, 1);
    checkOutput("post_rst_noerr", par_total + frm_total - par_snap - frm_snap, 0);
    popOne();

`ifdef PS2_SCANCODE_TAG_EN
    applyStimulus(8'hE0, 0, 1'b1, 11, 0, 0);
    applyStimulus(8'hF0, 0, 1'b1, 11, 0, 0);
    checkOutput("tag_prefix_absorbed", bus.count, 0);
    applyStimulus(8'h75, 0, 1'b1, 11, 0, 0);
    checkOutput("tag_count", bus.count, 1);
    checkOutput("tag_char",  bus.char, 8'h75);
    checkOutput("tag_ext",   bus.ext_tag, 1);
    checkOutput("tag_brk",   bus.brk_tag, 1);
`else
    applyStimulus(8'hE0, 0, 1'b1, 11, 0, 0);
    checkOutput("raw_e0_count", bus.count, 1);
    checkOutput("raw_e0_char",  bus.char, 8'hE0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised next-generation PS/2 device-to-host receiver.
- Adds input synchronisation, clock deglitching, parity and framing checks, and a frame timeout.
- Received bytes go into an internal show-ahead FIFO, so consumers pull bytes instead of catching a single-cycle strobe.
- Sits between the PS/2 connector pins and the keyboard/character consumer logic in the fpga_clk domain.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised ps2_clk samples required before the filtered clock changes; range 2..255.
- TIMEOUT_CYC, 50000: fpga_clk cycles allowed between falling edges inside a frame before it is aborted; ≥16.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2.

Ports:
- fpga_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- rdreq  in  1  pop FIFO head this cycle.
- clr_err  in  1  clear sticky error flags.
- char  out  8  FIFO head byte; valid when empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err_pulse  out  3  one-cycle error strobes: {overflow, frame_err, parity_err}.
- err_sticky  out  3  sticky copy of err_pulse, same bit order.

Behaviour:
- Synchronous reset (rst_n=0 at a rising edge):
  - FSM to IDLE; FIFO emptied.
  - char=0, empty=1, full=0, count=0, err_pulse=0, err_sticky=0.
  - Filtered clock = 1; filter counter and timeout counter = 0.
  - A frame in progress is discarded; no pulse is generated for it.
- Input path:
  - Both pins pass through a 2-flop synchroniser.
  - Filtered clock toggles only after FILTER_LEN consecutive synced samples differ from its current value.
  - A 1→0 transition of the filtered clock produces a one-cycle strobe. Data is sampled from the synchronised ps2_data in that same cycle.
- FSM (advances on strobe only):
  - IDLE: data=0 → DATA with bit_cnt=0. data=1 → stay (spurious edge ignored).
  - DATA: shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: par_ok = (data == ~^shift) (odd parity). Go to STOP.
  - STOP:
    - data=1 and par_ok → push byte.
    - data=1 and !par_ok → parity_err pulse; byte dropped.
    - data=0 → frame_err pulse; byte dropped. Parity is not reported in this case.
    - Always return to IDLE.
- Timeout:
  - In DATA/PARITY/STOP, the counter clears on every strobe and increments otherwise.
  - At TIMEOUT_CYC-1: frame_err pulse, FSM to IDLE, partial byte discarded.
  - In IDLE the counter is held at 0.
- FIFO (show-ahead):
  - Stop-bit strobe in cycle N → write at the end of cycle N; char/empty/count update in cycle N+1.
  - rdreq while empty → ignored, no error.
  - Push while full with no pop → byte dropped, overflow pulse.
  - Push and pop in the same cycle → both performed, count unchanged. This applies even when full; no overflow is reported.
  - Pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH).
- Errors:
  - err_sticky bits set on their pulse and clear on clr_err.
  - Pulse and clr_err in the same cycle → the set wins.

Optional Feature:
- Macro: PS2_SCANCODE_TAG_EN.
- Defined:
  - Adds outputs ext_tag (1) and brk_tag (1); the FIFO is widened to 10 bits.
  - Valid byte 0xE0 → sets pending_ext, not pushed.
  - Valid byte 0xF0 → sets pending_brk, not pushed.
  - Next valid non-prefix byte is pushed with the pending flags attached, then both flags clear.
  - Pending flags clear on reset and on any frame error/timeout.
- Undefined:
  - Every valid byte is pushed raw, including 0xE0/0xF0.
  - ext_tag and brk_tag ports do not exist.

Test Plan:
- Frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) at a 60 µs bit period → empty falls, char=0x1C, count=1; rdreq one cycle → empty=1.
- Frame 0x1C with parity bit 1 → err_pulse=3'b001 for one cycle, err_sticky[0]=1, FIFO stays empty; clr_err → err_sticky=0.
- Frame with stop bit 0 → err_pulse=3'b010; FIFO empty. Also stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles → frame_err pulse, then a clean frame 0x5A is received correctly.
- Push FIFO_DEPTH+1 bytes 0x00..0x10 without reads → full=1, count=16, overflow pulse on the 17th. Drain order is 0x00..0x0F. Push+pop in the same cycle while full → count stays 16, no overflow.
- 2-cycle glitches on ps2_clk (shorter than FILTER_LEN) during a frame, and rst_n low mid-frame → no extra bits accepted; after reset all outputs are at reset values and the next frame 0x29 is received.
- With PS2_SCANCODE_TAG_EN: frames E0, F0, 75 → a single entry with char=0x75, ext_tag=1, brk_tag=1, count=1.
